// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control unit.
package cpu_ctrl_pkg;

   // Controller sequencing states
   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRd,
      StMemWb,
      StMemWr,
      StExecR,
      StExecI,
      StAluWb,
      StBranch,
      StFault
   } state_e;

   // ALUControl encodings
   typedef enum logic [1:0] {
      AluAdd = 2'b00,
      AluSub = 2'b01,
      AluAnd = 2'b10,
      AluOrr = 2'b11
   } alu_ctrl_e;

   // ALUSrcB mux selects
   localparam logic [1:0] SrcBReg  = 2'b00;
   localparam logic [1:0] SrcBImm  = 2'b01;
   localparam logic [1:0] SrcBFour = 2'b10;

   // ResultSrc mux selects
   localparam logic [1:0] ResAluOut    = 2'b00;
   localparam logic [1:0] ResData      = 2'b01;
   localparam logic [1:0] ResAluResult = 2'b10;

   // Instr[27:26] classes
   localparam logic [1:0] OpDp     = 2'b00;
   localparam logic [1:0] OpMem    = 2'b01;
   localparam logic [1:0] OpBranch = 2'b10;
   localparam logic [1:0] OpUndef  = 2'b11;

   // Data-processing cmd field Funct[4:1]
   localparam logic [3:0] CmdAdd = 4'b0100;
   localparam logic [3:0] CmdSub = 4'b0010;
   localparam logic [3:0] CmdAnd = 4'b0000;
   localparam logic [3:0] CmdOrr = 4'b1100;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
// Counter ports exist only when PERF_CNT_EN is defined.
interface multicycle_ctrl_if
`ifdef PERF_CNT_EN
   #(parameter int unsigned CNT_W = 32)
`endif
   ;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       CondEx;
   logic       mem_ready;
   logic       mem_req;
   logic       IRWrite;
   logic       AdrSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic [1:0] ALUControl;
   logic [1:0] FlagW;
   logic       RegWrite;
   logic       MemWrite;
   logic       PCWrite;
   logic       fault;
`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cyc_cnt;
   logic [CNT_W-1:0] instr_cnt;
`endif

   // Controller side
   modport master (
      input  Op, Funct, Rd, CondEx, mem_ready,
      output mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
             ALUControl, FlagW, RegWrite, MemWrite, PCWrite, fault
`ifdef PERF_CNT_EN
      , output cyc_cnt, instr_cnt
`endif
   );

   // Datapath side
   modport slave (
      output Op, Funct, Rd, CondEx, mem_ready,
      input  mem_req, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
             ALUControl, FlagW, RegWrite, MemWrite, PCWrite, fault
`ifdef PERF_CNT_EN
      , input cyc_cnt, instr_cnt
`endif
   );

endinterface

// File: rtl/alu_dec.sv
// ALU decoder: maps the data-processing cmd field to ALUControl and flag-write
// enables, and flags cmd encodings the ALU cannot perform.
module alu_dec
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] Funct,      // Funct[4:0]; the I bit is consumed by the FSM
   input  logic       ALUOp,      // high only in execute states
   input  logic       CondEx,
   output logic [1:0] ALUControl,
   output logic [1:0] FlagW,
   output logic       illegal
);

   logic [1:0] alu_ctl;

   // Decode cmd, then let ALUOp choose between decoded op and plain ADD
   always_comb begin
      alu_ctl    = AluAdd;
      illegal    = 1'b0;
      ALUControl = AluAdd;
      FlagW      = 2'b00;
      case (Funct[4:1])
         CmdAdd:  alu_ctl = AluAdd;
         CmdSub:  alu_ctl = AluSub;
         CmdAnd:  alu_ctl = AluAnd;
         CmdOrr:  alu_ctl = AluOrr;
         default: illegal = 1'b1;
      endcase
      if (ALUOp) begin
         ALUControl = alu_ctl;
         FlagW[1]   = Funct[0] & CondEx;
         // C/V only meaningful for arithmetic ops
         FlagW[0]   = Funct[0] & CondEx & ((alu_ctl == AluAdd) | (alu_ctl == AluSub));
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: sequences the shared datapath through
// fetch/decode/execute/writeback, handles memory wait states with a timeout,
// and traps illegal encodings into a sticky fault state.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
`ifdef PERF_CNT_EN
   ,
   parameter int unsigned CNT_W = 32
`endif
) (
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master bus
);

   // Last not-ready cycle count before a timeout trips; ready in that cycle still wins
   localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

   state_e     state_q, state_d;
   logic [7:0] wait_q, wait_d;

   logic       mem_req, ir_write, adr_src, alu_src_a;
   logic [1:0] alu_src_b, result_src;
   logic       reg_write, mem_write, pc_write;
   logic       alu_op, illegal;
   logic [1:0] alu_control, flag_w;
   logic       rd_is_pc;

   assign alu_op   = (state_q == StExecR) | (state_q == StExecI);
   assign rd_is_pc = (bus.Rd == 4'hF);

   alu_dec u_alu_dec (
      .Funct      (bus.Funct[4:0]),
      .ALUOp      (alu_op),
      .CondEx     (bus.CondEx),
      .ALUControl (alu_control),
      .FlagW      (flag_w),
      .illegal    (illegal)
   );

   // State and wait-counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StFetch;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state and per-state datapath controls
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SrcBReg;
      result_src = ResAluOut;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      pc_write   = 1'b0;
      case (state_q)
         StFetch: begin
            mem_req    = 1'b1;
            alu_src_a  = 1'b1;
            alu_src_b  = SrcBFour;
            result_src = ResAluResult;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (wait_q == WaitLast) begin
               state_d = StFault;
            end
         end
         StDecode: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SrcBFour;
            result_src = ResAluResult;
            case (bus.Op)
               OpDp: begin
                  if (illegal)           state_d = StFault;
                  else if (bus.Funct[5]) state_d = StExecI;
                  else                   state_d = StExecR;
               end
               OpMem:    state_d = StMemAdr;
               OpBranch: state_d = StBranch;
               OpUndef:  state_d = StFault;
            endcase
         end
         StMemAdr: begin
            alu_src_b = SrcBImm;
            state_d   = bus.Funct[0] ? StMemRd : StMemWr;
         end
         StMemRd: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (bus.mem_ready)          state_d = StMemWb;
            else if (wait_q == WaitLast) state_d = StFault;
         end
         StMemWr: begin
            mem_req   = 1'b1;
            adr_src   = 1'b1;
            mem_write = bus.CondEx;
            if (bus.mem_ready)          state_d = StFetch;
            else if (wait_q == WaitLast) state_d = StFault;
         end
         StMemWb: begin
            result_src = ResData;
            reg_write  = bus.CondEx;
            pc_write   = bus.CondEx & rd_is_pc;
            state_d    = StFetch;
         end
         StExecR: state_d = StAluWb;
         StExecI: begin
            alu_src_b = SrcBImm;
            state_d   = StAluWb;
         end
         StAluWb: begin
            result_src = ResAluOut;
            reg_write  = bus.CondEx;
            pc_write   = bus.CondEx & rd_is_pc;
            state_d    = StFetch;
         end
         StBranch: begin
            alu_src_b  = SrcBImm;
            result_src = ResAluResult;
            pc_write   = bus.CondEx;
            state_d    = StFetch;
         end
         StFault: state_d = StFault;
         default: state_d = StFault;
      endcase
   end

   // Count consecutive stalled cycles within one access; any state change clears it
   always_comb begin
      wait_d = '0;
      if (mem_req && !bus.mem_ready && (state_d == state_q)) begin
         wait_d = wait_q + 8'd1;
      end
   end

   // Enables are forced low while reset is held so an aborted access writes nothing
   assign bus.mem_req    = mem_req & rst_n;
   assign bus.IRWrite    = ir_write & rst_n;
   assign bus.RegWrite   = reg_write & rst_n;
   assign bus.MemWrite   = mem_write & rst_n;
   assign bus.PCWrite    = pc_write & rst_n;
   assign bus.FlagW      = rst_n ? flag_w : 2'b00;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ResultSrc  = result_src;
   assign bus.ALUControl = alu_control;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == OpBranch, bus.Op == OpMem};
   assign bus.fault      = (state_q == StFault);

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d, instr_cnt_q, instr_cnt_d;
   logic             instr_done;

   assign instr_done = (state_d == StFetch) &&
                       ((state_q == StMemWb) || (state_q == StMemWr) ||
                        (state_q == StAluWb) || (state_q == StBranch));

   // Counter next-state; both wrap naturally
   always_comb begin
      cyc_cnt_d   = cyc_cnt_q + 1'b1;
      instr_cnt_d = instr_cnt_q + (instr_done ? 1'b1 : 1'b0);
   end

   // Counter registers, cleared by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cyc_cnt_q   <= '0;
         instr_cnt_q <= '0;
      end else begin
         cyc_cnt_q   <= cyc_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign bus.cyc_cnt   = cyc_cnt_q;
   assign bus.instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction list followed by random
// instructions, memory stalls and resets; a per-cycle scoreboard compares
// every control output against an instruction-level reference model.
module tb_multicycle_ctrl;

  localparam int unsigned WaitMax   = 15;
  localparam int          NumCycles = 4000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus_if ();

  multicycle_ctrl #(.WAIT_MAX(WaitMax)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef enum int {
    PFetch, PDecode, PAddr, PLoad, PLoadWb, PStore, PExecR, PExecI, PAluWb, PBranch, PDead
  } phase_e;

  typedef struct packed {
    logic       mem_req;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_ctl;
    logic [1:0] flag_w;
    logic       reg_write;
    logic       mem_write;
    logic       pc_write;
    logic       fault;
  } outs_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         cond;    // -1: random every cycle
    int         stall;   // not-ready cycles before each memory access completes
    int         rst_at;  // assert reset at this stall count inside a store, -1 never
  } instr_t;

  outs_t  exp_q[$];
  phase_e ph_q[$];
  instr_t dir_q[$];

  int checks = 0;
  int passes = 0;

  // Reference model state
  phase_e ph;
  instr_t cur, ir;
  int     stall, dead_cnt, cyc;

  // Index into the legal data-processing table, which is also the ALUControl code
  function automatic int cmd_index(logic [3:0] cmd);
    logic [3:0] tbl [4];
    tbl = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
    for (int i = 0; i < 4; i++) if (tbl[i] == cmd) return i;
    return -1;
  endfunction

  function automatic outs_t expect_outs(phase_e p, logic rst, logic [1:0] op, logic [5:0] fn,
                                        logic [3:0] rd, logic cond, logic rdy);
    outs_t o;
    int    k;
    o         = '0;
    o.imm_src = op;
    o.reg_src = {op == 2'b10, op == 2'b01};
    case (p)
      PFetch: begin
        o.mem_req = 1'b1; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10;
        o.ir_write = rdy; o.pc_write = rdy;
      end
      PDecode: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10; end
      PAddr:   o.alu_src_b = 2'b01;
      PLoad:   begin o.mem_req = 1'b1; o.adr_src = 1'b1; end
      PStore:  begin o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = cond; end
      PLoadWb, PAluWb: begin
        o.result_src = (p == PLoadWb) ? 2'b01 : 2'b00;
        o.reg_write  = cond;
        o.pc_write   = cond && (rd == 4'hF);
      end
      PExecR, PExecI: begin
        k           = cmd_index(fn[4:1]);
        o.alu_src_b = (p == PExecI) ? 2'b01 : 2'b00;
        o.alu_ctl   = 2'(k);
        o.flag_w[1] = fn[0] & cond;
        o.flag_w[0] = fn[0] & cond & (k < 2);
      end
      PBranch: begin o.alu_src_b = 2'b01; o.result_src = 2'b10; o.pc_write = cond; end
      default: o.fault = 1'b1;
    endcase
    if (!rst) begin
      o.mem_req = 1'b0; o.ir_write = 1'b0; o.reg_write = 1'b0;
      o.mem_write = 1'b0; o.pc_write = 1'b0; o.flag_w = 2'b00;
    end
    return o;
  endfunction

  task automatic push_dir(logic [1:0] op, logic [5:0] fn, logic [3:0] rd, int cond, int st,
                          int ra);
    instr_t t;
    t.op = op; t.funct = fn; t.rd = rd; t.cond = cond; t.stall = st; t.rst_at = ra;
    dir_q.push_back(t);
  endtask

  task automatic new_instr();
    int r;
    int stalls [16];
    logic [3:0] cmds [4];
    stalls = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 1, 14, 15, 19};
    cmds   = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
    if (dir_q.size() > 0) begin
      cur = dir_q.pop_front();
      return;
    end
    r         = $urandom_range(0, 15);
    cur.op    = (r < 7) ? 2'b00 : (r < 11) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
    cur.funct = 6'($urandom);
    if (cur.op == 2'b00 && $urandom_range(0, 7) != 0) cur.funct[4:1] = cmds[$urandom_range(0, 3)];
    cur.rd     = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
    cur.cond   = -1;
    cur.stall  = stalls[$urandom_range(0, 15)];
    cur.rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
  endtask

  // One cycle: choose inputs, record the expected outputs, advance the model
  task automatic step();
    logic   rdy, cond, rst, access;
    phase_e nxt;
    access = (ph == PFetch) || (ph == PLoad) || (ph == PStore);
    rdy    = access ? (stall >= cur.stall) : 1'($urandom_range(0, 1));
    cond   = (cur.cond < 0) ? 1'($urandom_range(0, 1)) : 1'(cur.cond);
    rst    = 1'b1;
    if (cur.rst_at >= 0 && ph == PStore && stall == cur.rst_at) rst = 1'b0;
    if (dir_q.size() == 0 && $urandom_range(0, 99) == 0) rst = 1'b0;
    if (ph == PDead && dead_cnt >= 3) rst = 1'b0;

    rst_n            = rst;
    bus_if.mem_ready = rdy;
    bus_if.CondEx    = cond;
    bus_if.Op        = ir.op;
    bus_if.Funct     = ir.funct;
    bus_if.Rd        = ir.rd;

    exp_q.push_back(expect_outs(ph, rst, ir.op, ir.funct, ir.rd, cond, rdy));
    ph_q.push_back(ph);

    if (!rst) begin
      ph = PFetch; stall = 0; dead_cnt = 0;
      new_instr();
      return;
    end
    nxt = ph;
    case (ph)
      PFetch: if (rdy) begin nxt = PDecode; ir = cur; end
      PDecode: begin
        if (ir.op == 2'b11) nxt = PDead;
        else if (ir.op == 2'b01) nxt = PAddr;
        else if (ir.op == 2'b10) nxt = PBranch;
        else if (cmd_index(ir.funct[4:1]) < 0) nxt = PDead;
        else nxt = ir.funct[5] ? PExecI : PExecR;
      end
      PAddr:  nxt = ir.funct[0] ? PLoad : PStore;
      PLoad:  if (rdy) nxt = PLoadWb;
      PStore: if (rdy) nxt = PFetch;
      PExecR, PExecI: nxt = PAluWb;
      PLoadWb, PAluWb, PBranch: nxt = PFetch;
      default: nxt = PDead;
    endcase
    if (access && !rdy && (stall + 1 == int'(WaitMax))) nxt = PDead;
    if (access && !rdy && nxt == ph) stall++;
    else stall = 0;
    if (ph == PDead) dead_cnt++;
    else dead_cnt = 0;
    if (nxt == PFetch && ph != PFetch) new_instr();
    ph = nxt;
  endtask

  task automatic check_bit(logic act, logic exp, string what);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s t=%0t: actual %b required %b", what, $time, act, exp);
  endtask

  // Monitor: compare every output once per cycle, away from the clock edge
  outs_t  mon_exp, mon_act;
  phase_e mon_ph;
  logic   after_rst = 1'b1;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_ph  = ph_q.pop_front();
      mon_act = '{bus_if.mem_req, bus_if.IRWrite, bus_if.AdrSrc, bus_if.ALUSrcA,
                  bus_if.ALUSrcB, bus_if.ResultSrc, bus_if.ImmSrc, bus_if.RegSrc,
                  bus_if.ALUControl, bus_if.FlagW, bus_if.RegWrite, bus_if.MemWrite,
                  bus_if.PCWrite, bus_if.fault};
      if (mon_act !== mon_exp)
        $display("FAIL outputs t=%0t phase=%s rst_n=%b: actual %h required %h",
                 $time, mon_ph.name(), rst_n, mon_act, mon_exp);
      check_bit(mon_act === mon_exp, 1'b1, "output vector");
      if (after_rst) check_bit(bus_if.fault, 1'b0, "reset state fault");
      if (mon_ph == PDead) check_bit(bus_if.fault, 1'b1, "fault state after trap or expired wait");
      after_rst = !rst_n;
    end
  end

  initial begin
    rst_n = 1'b0;
    bus_if.Op = 2'b00; bus_if.Funct = '0; bus_if.Rd = '0;
    bus_if.CondEx = 1'b0; bus_if.mem_ready = 1'b0;
    ir = '{op: 2'b00, funct: 6'b0, rd: 4'h0, cond: 0, stall: 0, rst_at: -1};

    push_dir(2'b00, 6'b101000, 4'h1, 1, 0, -1);    // ADD R1, imm
    push_dir(2'b01, 6'b011001, 4'h2, 1, 3, -1);    // LDR with 3 wait cycles
    push_dir(2'b01, 6'b011000, 4'h3, 0, 1, -1);    // STR, condition fails
    push_dir(2'b00, 6'b000101, 4'hF, 1, 0, -1);    // SUBS R15
    push_dir(2'b11, 6'b000000, 4'h0, 1, 0, -1);    // undefined op -> fault
    push_dir(2'b00, 6'b101000, 4'h1, 1, 15, -1);   // fetch timeout -> fault
    push_dir(2'b00, 6'b111001, 4'h4, 1, 14, -1);   // ready on last allowed cycle
    push_dir(2'b01, 6'b011000, 4'h5, 1, 5, 2);     // reset during store wait
    push_dir(2'b00, 6'b000001, 4'h6, 1, 0, -1);    // ANDS: only N/Z written
    push_dir(2'b00, 6'b001100, 4'h7, 1, 0, -1);    // illegal cmd -> fault
    push_dir(2'b10, 6'b000000, 4'h0, 1, 0, -1);    // taken branch
    push_dir(2'b10, 6'b000000, 4'h0, 0, 0, -1);    // not-taken branch
    push_dir(2'b01, 6'b011001, 4'hF, 1, 0, -1);    // LDR PC

    ph = PFetch; stall = 0; dead_cnt = 0;
    new_instr();
    @(posedge clk);
    #1;
    for (cyc = 0; cyc < NumCycles; cyc++) begin
      step();
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
